// File: rtl/stream_flags_pkg.sv
// Shared flag bit map and widths for the mflags/sflags streaming protocol.
package stream_flags_pkg;
    localparam int MF_W     = 4;
    localparam int SF_W     = 2;
    localparam int MF_VALID = 0;
    localparam int MF_SOP   = 1;
    localparam int MF_EOP   = 2;
    localparam int MF_ERR   = 3;
    localparam int SF_STALL = 0;
    localparam int SF_FLUSH = 1;

    // Single-beat frame from a free-running source: valid, sop and eop together.
    localparam logic [MF_W-1:0] MF_CONST_SRC = 4'b0111;
endpackage

// File: rtl/accum_dump_decim_if.sv
// One direction of an mflags/sflags stream: master drives data and mflags, slave drives sflags.
interface accum_dump_decim_if
    import stream_flags_pkg::*;
#(
    parameter int W = 32
);
    logic [W-1:0]    d0;
    logic [MF_W-1:0] mflags;
    logic [SF_W-1:0] sflags;

    modport master (output d0, output mflags, input sflags);
    modport slave  (input d0, input mflags, output sflags);
endinterface

// File: rtl/accum_dump_decim_sat_shift.sv
// Arithmetic right shift of the accumulator and reduction to W bits.
// ACCUM_DUMP_SAT_EN selects saturation (flagged on sat_o); otherwise the result wraps.
module sat_shift #(
    parameter int WA    = 34,
    parameter int W     = 32,
    parameter int SHIFT = 2
) (
    input  logic signed [WA-1:0] acc_i,
    output logic        [W-1:0]  res_o,
    output logic                 sat_o
);
    logic signed [WA-1:0] sh;
    assign sh = acc_i >>> SHIFT;

`ifdef ACCUM_DUMP_SAT_EN
    logic ovf;
    // Fits in W bits only when every bit from the W-1 sign position upward agrees.
    assign ovf = ~((&sh[WA-1:W-1]) | ~(|sh[WA-1:W-1]));

    always_comb begin
        sat_o = ovf;
        res_o = sh[W-1:0];
        if (ovf)
            res_o = sh[WA-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`else
    logic unused_hi;
    assign unused_hi = ^sh[WA-1:W];
    assign res_o     = sh[W-1:0];
    assign sat_o     = 1'b0;
`endif
endmodule

// File: rtl/accum_dump_decim.sv
// Decimating accumulate-and-dump: sums D accepted samples (or up to eop) and emits one
// scaled result into a single-entry output register. Optional macro: ACCUM_DUMP_SAT_EN.
module accum_dump_decim
    import stream_flags_pkg::*;
#(
    parameter int W     = 32,
    parameter int D     = 4,
    parameter int SHIFT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    accum_dump_decim_if.slave       uc_i,
    accum_dump_decim_if.master      cd_o
);
    localparam int WA = W + $clog2(D);
    localparam int CW = $clog2(D + 1);

    logic signed [WA-1:0] acc_q, acc_d, x;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_acc_q, err_acc_d;
    logic                 first_q, first_d;
    logic [W-1:0]         d0_q;
    logic [MF_W-1:0]      mf_q;
    logic [W-1:0]         res;
    logic                 sat, flush, stall, accept, dump;
    logic                 in_sop, in_eop, in_err;

    assign in_sop = uc_i.mflags[MF_SOP];
    assign in_eop = uc_i.mflags[MF_EOP];
    assign in_err = uc_i.mflags[MF_ERR];

    // Flush wins over stall so upstream is never held during a flush cycle.
    assign flush       = cd_o.sflags[SF_FLUSH];
    assign stall       = mf_q[MF_VALID] & cd_o.sflags[SF_STALL] & ~flush;
    assign uc_i.sflags = {1'b0, stall};
    assign accept      = uc_i.mflags[MF_VALID] & ~stall & ~flush;

    assign x = {{(WA-W){uc_i.d0[W-1]}}, uc_i.d0};

    always_comb begin
        acc_d     = acc_q + x;
        cnt_d     = cnt_q + CW'(1);
        err_acc_d = err_acc_q | in_err;
        first_d   = first_q;
        if (in_sop) begin
            acc_d     = x;
            cnt_d     = CW'(1);
            err_acc_d = in_err;
            first_d   = 1'b1;
        end
    end

    assign dump = accept & ((cnt_d == CW'(D)) | in_eop);

    sat_shift #(.WA(WA), .W(W), .SHIFT(SHIFT)) u_sat_shift (
        .acc_i (acc_d),
        .res_o (res),
        .sat_o (sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            first_q   <= 1'b1;
            d0_q      <= '0;
            mf_q      <= '0;
        end else if (flush) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            first_q   <= 1'b1;
            mf_q      <= '0;
        end else begin
            if (mf_q[MF_VALID] && !cd_o.sflags[SF_STALL])
                mf_q <= '0;
            // An accept with the register full implies it drains this cycle, so overwrite is safe.
            if (dump) begin
                d0_q      <= res;
                mf_q      <= {err_acc_d | sat, in_eop, first_d, 1'b1};
                acc_q     <= '0;
                cnt_q     <= '0;
                err_acc_q <= 1'b0;
                first_q   <= 1'b0;
            end else if (accept) begin
                acc_q     <= acc_d;
                cnt_q     <= cnt_d;
                err_acc_q <= err_acc_d;
                first_q   <= first_d;
            end
        end
    end

    assign cd_o.d0     = d0_q;
    assign cd_o.mflags = mf_q;
endmodule

// File: tb/tb_accum_dump_decim.sv
// Directed table-driven bench: DUT A (W=32,D=4,SHIFT=2) and DUT B (W=8,D=4,SHIFT=0).
module tb_accum_dump_decim;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accum_dump_decim_if #(.W(32)) ua ();
    accum_dump_decim_if #(.W(32)) da ();
    accum_dump_decim_if #(.W(8))  ub ();
    accum_dump_decim_if #(.W(8))  db ();

    accum_dump_decim #(.W(32), .D(4), .SHIFT(2)) dut_a (.clk(clk), .rst(rst), .uc_i(ua), .cd_o(da));
    accum_dump_decim #(.W(8),  .D(4), .SHIFT(0)) dut_b (.clk(clk), .rst(rst), .uc_i(ub), .cd_o(db));

`ifdef ACCUM_DUMP_SAT_EN
    localparam logic [31:0] POS_D = 32'h7F, NEG_D = 32'h80;
    localparam logic [3:0]  OVF_MF = 4'b1001;
`else
    localparam logic [31:0] POS_D = 32'h90, NEG_D = 32'h70;
    localparam logic [3:0]  OVF_MF = 4'b0001;
`endif

    typedef struct {
        bit          sel;
        logic [31:0] d;
        logic [3:0]  mf;
        logic [1:0]  dc;
        logic        exp_stall;
        logic [3:0]  exp_mf;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tv[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(bit sel, logic [31:0] d, logic [3:0] mf, logic [1:0] dc,
                                logic st, logic [3:0] emf, logic [31:0] ed);
        vec_t v;
        v.sel = sel; v.d = d; v.mf = mf; v.dc = dc;
        v.exp_stall = st; v.exp_mf = emf; v.exp_d = ed;
        tv.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [31:0] d, input logic [3:0] mf, input logic [1:0] dc);
        ua.d0 = '0; ua.mflags = '0; da.sflags = '0;
        ub.d0 = '0; ub.mflags = '0; db.sflags = '0;
        if (sel) begin
            ub.d0 = d[7:0]; ub.mflags = mf; db.sflags = dc;
        end else begin
            ua.d0 = d; ua.mflags = mf; da.sflags = dc;
        end
    endtask

    initial begin
        drive(1'b0, '0, '0, '0);
        #1;
        chk("reset A d0", da.d0, 32'h0);
        chk("reset A mflags", {28'h0, da.mflags}, 32'h0);
        chk("reset A sflags", {30'h0, ua.sflags}, 32'h0);
        chk("reset B mflags", {28'h0, db.mflags}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // DUT A: basic blocks
        add(0, 4,  4'b0011, 2'b00, 0, 4'b0000, 0);
        add(0, 8,  4'b0001, 2'b00, 0, 4'b0000, 0);
        add(0, 12, 4'b0001, 2'b00, 0, 4'b0000, 0);
        add(0, 16, 4'b0001, 2'b00, 0, 4'b0011, 10);
        add(0, 1,  4'b0001, 2'b00, 0, 4'b0000, 10);
        add(0, 1,  4'b0001, 2'b00, 0, 4'b0000, 10);
        add(0, 1,  4'b0001, 2'b00, 0, 4'b0000, 10);
        add(0, 1,  4'b0001, 2'b00, 0, 4'b0001, 1);
        // downstream stall with output full, input held
        for (int k = 0; k < 5; k++) add(0, 20, 4'b0001, 2'b01, 1, 4'b0001, 1);
        add(0, 20, 4'b0001, 2'b00, 0, 4'b0000, 1);
        add(0, 24, 4'b0001, 2'b00, 0, 4'b0000, 1);
        add(0, 28, 4'b0001, 2'b00, 0, 4'b0000, 1);
        add(0, 32, 4'b0001, 2'b00, 0, 4'b0001, 26);
        add(0, 0,  4'b0000, 2'b01, 1, 4'b0001, 26);
        add(0, 0,  4'b0000, 2'b00, 0, 4'b0000, 26);
        add(0, 0,  4'b0000, 2'b01, 0, 4'b0000, 26);
        // negative block with err on one beat, then clean block
        add(0, 32'hFFFFFFFC, 4'b0001, 2'b00, 0, 4'b0000, 26);
        add(0, 32'hFFFFFFF8, 4'b1001, 2'b00, 0, 4'b0000, 26);
        add(0, 32'hFFFFFFF4, 4'b0001, 2'b00, 0, 4'b0000, 26);
        add(0, 32'hFFFFFFF0, 4'b0001, 2'b00, 0, 4'b1001, 32'hFFFFFFF6);
        add(0, 2, 4'b0001, 2'b00, 0, 4'b0000, 32'hFFFFFFF6);
        add(0, 2, 4'b0001, 2'b00, 0, 4'b0000, 32'hFFFFFFF6);
        add(0, 2, 4'b0001, 2'b00, 0, 4'b0000, 32'hFFFFFFF6);
        add(0, 2, 4'b0001, 2'b00, 0, 4'b0001, 2);
        // eop dump while draining, then single-sample sop+eop
        add(0, 7,  4'b0101, 2'b00, 0, 4'b0101, 1);
        add(0, 12, 4'b0111, 2'b00, 0, 4'b0111, 3);
        // sop mid-block discards the partial sum
        add(0, 100, 4'b0001, 2'b00, 0, 4'b0000, 3);
        add(0, 8,   4'b0011, 2'b00, 0, 4'b0000, 3);
        add(0, 8,   4'b0001, 2'b00, 0, 4'b0000, 3);
        add(0, 8,   4'b0001, 2'b00, 0, 4'b0000, 3);
        add(0, 8,   4'b0001, 2'b00, 0, 4'b0011, 8);
        // flush drops partial sum and same-cycle input; restores first
        add(0, 4, 4'b0001, 2'b00, 0, 4'b0000, 8);
        add(0, 4, 4'b0001, 2'b10, 0, 4'b0000, 8);
        add(0, 3, 4'b0001, 2'b00, 0, 4'b0000, 8);
        add(0, 3, 4'b0001, 2'b00, 0, 4'b0000, 8);
        add(0, 3, 4'b0001, 2'b00, 0, 4'b0000, 8);
        add(0, 3, 4'b0001, 2'b00, 0, 4'b0011, 3);
        add(0, 9, 4'b0001, 2'b11, 0, 4'b0000, 3);

        // DUT B: unscaled sums, eop frame, sop restart, overflow
        add(1, 1, 4'b0011, 2'b00, 0, 4'b0000, 0);
        add(1, 1, 4'b0001, 2'b00, 0, 4'b0000, 0);
        add(1, 1, 4'b0001, 2'b00, 0, 4'b0000, 0);
        add(1, 1, 4'b0001, 2'b00, 0, 4'b0011, 4);
        add(1, 5, 4'b0001, 2'b00, 0, 4'b0000, 4);
        add(1, 5, 4'b0101, 2'b00, 0, 4'b0101, 10);
        add(1, 3, 4'b0011, 2'b00, 0, 4'b0000, 10);
        add(1, 3, 4'b0001, 2'b00, 0, 4'b0000, 10);
        add(1, 3, 4'b0001, 2'b00, 0, 4'b0000, 10);
        add(1, 3, 4'b0001, 2'b00, 0, 4'b0011, 12);
        add(1, 100, 4'b0001, 2'b00, 0, 4'b0000, 12);
        add(1, 100, 4'b0001, 2'b00, 0, 4'b0000, 12);
        add(1, 100, 4'b0001, 2'b00, 0, 4'b0000, 12);
        add(1, 100, 4'b0001, 2'b00, 0, OVF_MF, POS_D);
        add(1, 32'h9C, 4'b0001, 2'b00, 0, 4'b0000, POS_D);
        add(1, 32'h9C, 4'b0001, 2'b00, 0, 4'b0000, POS_D);
        add(1, 32'h9C, 4'b0001, 2'b00, 0, 4'b0000, POS_D);
        add(1, 32'h9C, 4'b0001, 2'b00, 0, OVF_MF, NEG_D);

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].sel, tv[i].d, tv[i].mf, tv[i].dc);
            #1;
            chk($sformatf("row%0d stall", i),
                {31'h0, tv[i].sel ? ub.sflags[0] : ua.sflags[0]}, {31'h0, tv[i].exp_stall});
            @(posedge clk);
            #1;
            if (tv[i].sel) begin
                chk($sformatf("row%0d mflags", i), {28'h0, db.mflags}, {28'h0, tv[i].exp_mf});
                chk($sformatf("row%0d d0", i), {24'h0, db.d0}, {24'h0, tv[i].exp_d[7:0]});
            end else begin
                chk($sformatf("row%0d mflags", i), {28'h0, da.mflags}, {28'h0, tv[i].exp_mf});
                chk($sformatf("row%0d d0", i), da.d0, tv[i].exp_d);
            end
        end

        // Reset mid-frame on A: a full block, then 2 beats of the next, then async reset.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(1'b0, 32'd4, 4'b0001, 2'b00);
        end
        @(posedge clk);
        #1;
        chk("pre-reset d0", da.d0, 32'd4);
        drive(1'b0, '0, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst d0", da.d0, 32'h0);
        chk("midrst mflags", {28'h0, da.mflags}, 32'h0);
        chk("midrst sflags", {30'h0, ua.sflags}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 32'd8, 4'b0001, 2'b00);
            @(posedge clk);
            #1;
            if (k < 3) chk($sformatf("postrst beat%0d mflags", k), {28'h0, da.mflags}, 32'h0);
        end
        chk("postrst mflags", {28'h0, da.mflags}, 32'h3);
        chk("postrst d0", da.d0, 32'd8);
        @(negedge clk);
        drive(1'b0, '0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
